// File: rtl/seg_pkg.sv
// Shared types and constants for the scanned 4-digit 7-segment display.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam int         NUM_DIGITS = 4;

    // Leading-zero test: digit k is blank when it and every higher nibble are zero.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
        logic res;
        res = 1'b0;
        case (k)
            2'd3:    res = (v[15:12] == 4'h0);
            2'd2:    res = (v[15:8]  == 8'h00);
            2'd1:    res = (v[15:4]  == 12'h000);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to active-low 7-segment glyph; A-F render as a dash.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH;
        case (nibble)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Round-robin scan of four BCD digits onto one shared seg bus, with per-slot
// anti-ghost blanking and a pending buffer that only swaps in at frame start.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000,
    parameter int LZ_SUPPRESS     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [6:0]  seg,
    output logic [3:0]  LED_Select,
    output logic        frame_done
);

    localparam int              CW         = $clog2(TICKS_PER_DIGIT);
    localparam int              DW         = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0]   SLOT_LAST  = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [DW-1:0]   LAST_DIG   = DW'(NUM_DIGITS - 1);

    scan_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] dig, dig_nxt;
    logic          boundary;
    logic          frame_end;

    logic [15:0]   pending, shown;
    logic          full;

    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          suppress;
    logic [6:0]    seg_nxt;
    logic [3:0]    sel_nxt;

    // Next-state logic; boundary marks the edge that enters BLANK of digit 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dig_nxt   = dig;
        boundary  = 1'b0;
        frame_end = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            dig_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    dig_nxt   = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST)
                        state_nxt = DRIVE;
                end
                DRIVE: begin
                    if (cnt == SLOT_LAST) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        dig_nxt   = dig + 1'b1;
                        if (dig == LAST_DIG) begin
                            boundary  = 1'b1;
                            frame_end = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            dig   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dig   <= dig_nxt;
        end
    end

    // full blocks new loads, so a swap and a handshake never hit the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            full    <= 1'b0;
            shown   <= '0;
        end else begin
            if (boundary && full) begin
                shown <= pending;
                full  <= 1'b0;
            end
            if (load_valid && !full) begin
                pending <= digits_in;
                full    <= 1'b1;
            end
        end
    end

    assign load_ready = !full;

    assign nibble   = shown[{dig, 2'b00} +: 4];
    assign suppress = (LZ_SUPPRESS != 0) && lz_blank(shown, dig);

    bcd_to_7seg u_dec (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        seg_nxt = SEG_BLANK;
        sel_nxt = 4'hF;
        if (enable && state == DRIVE && !suppress) begin
            seg_nxt = glyph;
            sel_nxt = ~(4'b0001 << dig);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= SEG_BLANK;
            LED_Select <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            LED_Select <= sel_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller at 10 ticks/slot, 2 blank ticks.
module tb_seg_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits_in;
    logic        load_valid;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  LED_Select;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_controller #(
        .TICKS_PER_DIGIT (10),
        .BLANK_TICKS     (2),
        .LZ_SUPPRESS     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .seg        (seg),
        .LED_Select (LED_Select),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // {seg, LED_Select, frame_done, load_ready}
    function automatic logic [31:0] pins();
        return {19'd0, seg, LED_Select, frame_done, load_ready};
    endfunction

    function automatic logic [31:0] dark(input logic rdy);
        return {19'd0, 7'h7F, 4'hF, 1'b0, rdy};
    endfunction

    // Checks n consecutive cycles of a frame, sample i showing slot position i.
    task automatic scan(input int fr, input int n, input logic [3:0][6:0] g,
                        input logic [3:0] lit, input int rlo, input int rhi);
        int         d, c;
        logic       on;
        logic [6:0] s_e;
        logic [3:0] a_e;
        logic       r_e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d   = i / 10;
            c   = i % 10;
            on  = lit[d] && (c >= 2);
            s_e = on ? g[d] : 7'h7F;
            a_e = on ? ~(4'b0001 << d) : 4'hF;
            r_e = !(i >= rlo && i <= rhi);
            chk($sformatf("scan f%0d i%0d", fr, i), pins(),
                {19'd0, s_e, a_e, (i == 39), r_e});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        digits_in  = 16'h0000;
        load_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_seg",   {25'd0, seg},        32'h7F);
        chk("rst_sel",   {28'd0, LED_Select}, 32'hF);
        chk("rst_fd",    {31'd0, frame_done}, 32'h0);
        chk("rst_ready", {31'd0, load_ready}, 32'h1);

        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("start_idle", pins(), dark(1'b1));

        // Blank display: only digit 0 lit with '0'
        scan(0, 40, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 40, -1);

        // Load 1234 mid-frame, then hold 00A0 while full
        fork
            scan(1, 40, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 6, 38);
            begin
                repeat (6) @(negedge clk);
                digits_in  = 16'h1234;
                load_valid = 1'b1;
                @(negedge clk);
                load_valid = 1'b0;
                repeat (4) @(negedge clk);
                digits_in  = 16'h00A0;
                load_valid = 1'b1;
            end
        join

        // 1234 on screen, 00A0 pending; drop enable during digit 2 DRIVE
        fork
            scan(2, 25, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 0, 24);
            begin
                @(negedge clk);
                load_valid = 1'b0;
            end
        join
        enable = 1'b0;
        @(negedge clk);
        chk("en_off_dark", pins(), dark(1'b0));
        @(negedge clk);
        chk("en_off_hold", pins(), dark(1'b0));
        enable = 1'b1;
        @(negedge clk);
        chk("reen_idle", pins(), dark(1'b1));

        // Retained pending 00A0 swapped in on re-enable
        scan(3, 40, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b0011, 40, -1);

        // Load 4321, then async reset during digit 1 DRIVE
        fork
            scan(4, 16, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b0011, 4, 15);
            begin
                repeat (4) @(negedge clk);
                digits_in  = 16'h4321;
                load_valid = 1'b1;
                @(negedge clk);
                load_valid = 1'b0;
            end
        join
        #2 reset = 1'b0;
        #1 chk("async_rst", pins(), dark(1'b1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", pins(), dark(1'b1));

        // Pending was discarded: back to 0000
        scan(5, 40, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 40, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexing scheduler for the shared 4-digit 7-segment display: owns the single `seg` bus and the `LED_Select` anode lines and shares them round-robin among four BCD digits. Sits between the counting logic (cascaded BCD counters) and the board pins. Replaces the fixed single-digit drive with a scanned, ghost-free, tear-free display. New values are accepted through a valid/ready handshake and applied only at frame boundaries.

## Interface
- `TICKS_PER_DIGIT`, 100000: clk cycles per digit slot (1 kHz/digit at 100 MHz); must be greater than `BLANK_TICKS`.
- `BLANK_TICKS`, 1000: cycles of anti-ghost blanking at the start of each slot; ≥1.
- `LZ_SUPPRESS`, 1: 1 = blank leading zeros on digits 3..1.
- `clk  input  1`  system clock, 100 MHz.
- `reset  input  1`  asynchronous, active-low reset.
- `enable  input  1`  1 = scan; 0 = display dark, FSM idle.
- `digits_in  input  16`  {d3,d2,d1,d0} BCD nibbles, d0 = rightmost.
- `load_valid  input  1`  `digits_in` is valid.
- `load_ready  output  1`  pending buffer empty; transfer occurs when valid&&ready.
- `seg  output  7`  {g,f,e,d,c,b,a}, active-low.
- `LED_Select  output  4`  active-low anode select; digit k drives bit k low.
- `frame_done  output  1`  1-cycle pulse at the end of digit 3's slot.

## Operation
- FSM states:
  - IDLE: entered on reset, or while `enable`=0.
  - BLANK: the first `BLANK_TICKS` cycles of a slot.
  - DRIVE: the remaining `TICKS_PER_DIGIT-BLANK_TICKS` cycles of the slot.
- Transitions:
  - IDLE→BLANK(digit 0) when `enable`=1.
  - BLANK→DRIVE when the slot counter reaches `BLANK_TICKS-1`.
  - DRIVE→BLANK(next digit) when the slot counter reaches `TICKS_PER_DIGIT-1`.
  - Digit index wraps 3→0.
  - Any state→IDLE when `enable`=0; the slot counter and digit index clear.
- Two 16-bit registers: `pending` (with a full flag) and `shown`.
  - A handshake loads `pending` and sets full.
  - At a frame boundary (entering BLANK of digit 0, including from IDLE): if full, `shown`←`pending` and full clears.
- `load_ready` = !full.
  - A load accepted on a boundary cycle is not applied at that boundary; it goes to the next frame.
- Decode per digit:
  - 0–9 use standard glyphs; '0'=1000000, '1'=1111001, '8'=0000000.
  - Nibbles A–F show a dash, 0111111.
- Leading-zero suppression (`LZ_SUPPRESS`=1): digit k (k=3..1) is blank when its nibble and all higher nibbles are 0. Digit 0 is never suppressed.
  - A suppressed digit holds `LED_Select`=1111 for the whole slot; its timing is unchanged.
- BLANK output: `seg`=1111111, `LED_Select`=1111.
- DRIVE output: glyph of `shown[digit]`, `LED_Select`=~(1<<digit).
- IDLE output: dark.

## Timing
- Reset values: `seg`=1111111, `LED_Select`=1111, `frame_done`=0, `load_ready`=1, `shown`=0000, `pending` empty, state IDLE.
- All outputs are registered. Pins reflect the state/counter of the previous cycle, so output latency is 1 cycle after any state change.
- Frame = 4·`TICKS_PER_DIGIT` cycles. Each slot lights its anode for exactly `TICKS_PER_DIGIT-BLANK_TICKS` consecutive cycles.
- `frame_done` is asserted (registered) in the cycle after the last DRIVE cycle of digit 3.
- `load_ready`:
  - Falls in the cycle after acceptance.
  - Rises in the cycle after the boundary that empties `pending`.
- `enable` deassert mid-slot: outputs go dark 1 cycle later; `pending` and `shown` are retained.
- Reset mid-frame: immediate asynchronous return to reset values; `pending` is discarded.
- The slot counter width is $clog2(`TICKS_PER_DIGIT`). Counters never exceed their terminal count; no overflow path exists.

## Structure
- Shared package `seg_pkg`:
  - FSM state enum (IDLE/BLANK/DRIVE).
  - Glyph constants SEG_BLANK and SEG_DASH.
  - Digit count constant NUM_DIGITS=4.
- Sub-module `bcd_to_7seg`: combinational nibble→glyph decoder producing active-low {g..a} with dash for A–F. Instantiated once on the muxed nibble.
- Handshake/pending buffer and scan FSM live in the top module.

## Test plan
Run with `TICKS_PER_DIGIT`=10 and `BLANK_TICKS`=2.
- Reset released, `enable`=1, no load:
  - Digits 3..1 dark for the whole frame (LZ suppression of 0000).
  - Digit 0 shows `seg`=1000000 with `LED_Select`=1110 for 8 cycles per 40-cycle frame.
- Load 16'h1234 mid-frame:
  - `load_ready` drops the next cycle.
  - The current frame is unchanged.
  - The next frame shows d3=4'h1 (`seg`=1111001, `LED_Select`=0111).
  - `load_ready` returns the cycle after the boundary.
- Second load while full: `load_valid` held with `load_ready`=0 → no transfer; the first value is displayed first, then the held value one frame later.
- Load 16'h00A0:
  - d3 and d2 suppressed.
  - d1 shows dash 0111111.
  - d0 shows '0'.
- `enable` dropped during DRIVE of digit 2:
  - Dark (1111111/1111) one cycle later.
  - On re-enable, a BLANK of digit 0 starts with 2 dark cycles.
- Async reset asserted mid-DRIVE:
  - All outputs take reset values without a clock edge.
  - `pending` is cleared and `load_ready`=1.
